keypad_scanner: RTL and testbench

Scans a 4x4 matrix keypad by driving one row low at a time, reads the column lines after they pass through the two-flop input synchronizer, debounces the press, and emits a single-cycle strobe with a 4-bit key code. It sits directly downstream of the per-column synchronizers and upstream of the display/key-history logic. It guarantees exactly one `key_valid` pulse per physical press, however long the key is held.

---
 rtl/keypad_scanner.sv | 151 +++++++++++++++
 tb/tb_keypad_scanner.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 matrix keypad scanner with press/release debounce
module keypad_scanner #(
  parameter int SCAN_CYCLES     = 1000,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic [3:0] cols,
  output logic [3:0] rows,
  output logic [3:0] key,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DW  = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam int DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DW-1:0]  DWELL_LAST = DW'(SCAN_CYCLES - 1);
  localparam logic [DBW-1:0] DEB_LAST   = DBW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_PRESSED  = 2'd2,
    ST_RELEASE  = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [1:0]     row_idx_q, row_idx_d;
  logic [DW-1:0]  dwell_q, dwell_d;
  logic [DBW-1:0] deb_q, deb_d;
  logic [3:0]     cap_q, cap_d;
  logic [3:0]     rows_q, rows_d;
  logic [3:0]     key_q, key_d;
  logic           key_valid_q, key_valid_d;
  logic           key_held_q, key_held_d;

  // {valid, column index}: valid only when exactly one column line is low
  function automatic logic [2:0] col_decode(input logic [3:0] c);
    case (c)
      4'b1110: col_decode = 3'b100;
      4'b1101: col_decode = 3'b101;
      4'b1011: col_decode = 3'b110;
      4'b0111: col_decode = 3'b111;
      default: col_decode = 3'b000;
    endcase
  endfunction

  logic [2:0] cols_dec;
  logic [2:0] cap_dec;
  assign cols_dec = col_decode(cols);
  assign cap_dec  = col_decode(cap_q);

  // Next-state logic: scan rows, debounce press, hold, debounce release
  always_comb begin
    state_d     = state_q;
    row_idx_d   = row_idx_q;
    dwell_d     = dwell_q;
    deb_d       = deb_q;
    cap_d       = cap_q;
    key_d       = key_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;
    case (state_q)
      ST_SCAN: begin
        if (dwell_q == DWELL_LAST) begin
          if (cols_dec[2]) begin
            cap_d   = cols;
            deb_d   = '0;
            state_d = ST_DEBOUNCE;
          end else begin
            row_idx_d = row_idx_q + 2'd1;
            dwell_d   = '0;
          end
        end else begin
          dwell_d = dwell_q + DW'(1);
        end
      end
      ST_DEBOUNCE: begin
        if (cols == cap_q) begin
          if (deb_q == DEB_LAST) begin
            state_d     = ST_PRESSED;
            key_d       = {row_idx_q, cap_dec[1:0]};
            key_valid_d = 1'b1;
            key_held_d  = 1'b1;
          end else begin
            deb_d = deb_q + DBW'(1);
          end
        end else begin
          state_d = ST_SCAN;
          dwell_d = '0;
        end
      end
      ST_PRESSED: begin
        if (cols == 4'b1111) begin
          deb_d   = '0;
          state_d = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (cols == 4'b1111) begin
          if (deb_q == DEB_LAST) begin
            state_d    = ST_SCAN;
            key_held_d = 1'b0;
            row_idx_d  = row_idx_q + 2'd1;
            dwell_d    = '0;
          end else begin
            deb_d = deb_q + DBW'(1);
          end
        end else begin
          state_d = ST_PRESSED;
        end
      end
      default: begin
        state_d = ST_SCAN;
        dwell_d = '0;
      end
    endcase
    rows_d = ~(4'b0001 << row_idx_d);
  end

  // State register with asynchronous active-low reset
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= ST_SCAN;
      row_idx_q   <= 2'd0;
      dwell_q     <= '0;
      deb_q       <= '0;
      cap_q       <= 4'b1111;
      rows_q      <= 4'b1110;
      key_q       <= 4'd0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_idx_q   <= row_idx_d;
      dwell_q     <= dwell_d;
      deb_q       <= deb_d;
      cap_q       <= cap_d;
      rows_q      <= rows_d;
      key_q       <= key_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

  assign rows      = rows_q;
  assign key       = key_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - self-checking bench for keypad_scanner
module tb_keypad_scanner;

  localparam int SC = 4;
  localparam int DC = 8;

  logic       clk;
  logic       nrst;
  logic [3:0] cols;
  logic [3:0] rows;
  logic [3:0] key;
  logic       key_valid;
  logic       key_held;

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  keypad_scanner #(.SCAN_CYCLES(SC), .DEBOUNCE_CYCLES(DC)) dut (
    .clk(clk), .nrst(nrst), .cols(cols), .rows(rows),
    .key(key), .key_valid(key_valid), .key_held(key_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Physical keypad: pressed[r*4+c] closes row r to column c
  logic [15:0] pressed;
  logic [3:0]  raw;
  logic [3:0]  sync1 = 4'hF;

  always_comb begin
    raw = 4'hF;
    for (int r = 0; r < 4; r++)
      if (!rows[r])
        for (int c = 0; c < 4; c++)
          if (pressed[r*4+c]) raw[c] = 1'b0;
  end

  initial cols = 4'hF;
  // Two-cycle column synchronizer in front of the DUT
  always @(posedge clk) begin
    sync1 <= raw;
    cols  <= sync1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: mode 0 scanning, 1 confirming a press, 2 key down, 3 confirming release
  int         m_mode, m_row, m_tick, m_run;
  logic [3:0] m_pat, m_key;
  bit         m_valid, m_held;

  function automatic int zeros(input logic [3:0] c);
    int n = 0;
    for (int i = 0; i < 4; i++) if (!c[i]) n++;
    return n;
  endfunction

  function automatic int zero_pos(input logic [3:0] c);
    for (int i = 0; i < 4; i++) if (!c[i]) return i;
    return 0;
  endfunction

  // Model advances once per clock from the same column sample the DUT sees
  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      m_mode <= 0; m_row <= 0; m_tick <= 0; m_run <= 0;
      m_pat <= 4'hF; m_key <= 4'd0; m_valid <= 1'b0; m_held <= 1'b0;
    end else begin
      m_valid <= 1'b0;
      if (m_mode == 0) begin
        if (m_tick == SC - 1) begin
          if (zeros(cols) == 1) begin
            m_pat <= cols; m_run <= 0; m_mode <= 1;
          end else begin
            m_row <= (m_row + 1) % 4; m_tick <= 0;
          end
        end else m_tick <= m_tick + 1;
      end else if (m_mode == 1) begin
        if (cols != m_pat) begin
          m_mode <= 0; m_tick <= 0;
        end else if (m_run + 1 == DC) begin
          m_mode <= 2; m_valid <= 1'b1; m_held <= 1'b1;
          m_key <= 4'(m_row * 4 + zero_pos(m_pat));
        end else m_run <= m_run + 1;
      end else if (m_mode == 2) begin
        if (cols == 4'hF) begin m_run <= 0; m_mode <= 3; end
      end else begin
        if (cols != 4'hF) m_mode <= 2;
        else if (m_run + 1 == DC) begin
          m_mode <= 0; m_held <= 1'b0; m_row <= (m_row + 1) % 4; m_tick <= 0;
        end else m_run <= m_run + 1;
      end
    end
  end

  // Cycle-by-cycle comparison against the model, plus pulse bookkeeping
  bit prev_valid = 1'b0;
  always @(negedge clk) begin
    check("rows", 32'(rows), 32'(4'hF ^ (4'h1 << m_row)));
    check("key", 32'(key), 32'(m_key));
    check("key_valid", 32'(key_valid), 32'(m_valid));
    check("key_held", 32'(key_held), 32'(m_held));
    if (prev_valid) check("valid_back_to_back", 32'(key_valid), 32'd0);
    prev_valid = key_valid;
    if (key_valid) pulses++;
  end

  task automatic wait_pulse(input int maxc, output bit got);
    got = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (key_valid) begin got = 1'b1; break; end
    end
  endtask

  // Cycles from the first all-released column sample until key_held drops
  task automatic measure_release(output int n);
    int k = 0;
    n = -1;
    while (cols != 4'hF && k < 20) begin @(negedge clk); k++; end
    if (cols == 4'hF) begin
      n = 0;
      while (key_held && n < 60) begin @(negedge clk); n++; end
    end
  endtask

  initial begin
    bit got;
    int p0, n;
    logic [3:0] seen;
    logic [3:0] exp_rows [4];
    exp_rows[0] = 4'b1101; exp_rows[1] = 4'b1011;
    exp_rows[2] = 4'b0111; exp_rows[3] = 4'b1110;
    pressed = 16'h0;
    nrst = 1'b0;

    // Reset and idle scan
    repeat (3) @(negedge clk);
    check("reset_rows", 32'(rows), 32'hE);
    check("reset_key", 32'(key), 32'h0);
    check("reset_held", 32'(key_held), 32'h0);
    #2 nrst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      repeat (SC) @(negedge clk);
      check("idle_rows_seq", 32'(rows), 32'(exp_rows[i]));
    end
    check("idle_no_pulse", 32'(pulses), 32'd0);

    // Clean press row 2 col 1
    p0 = pulses;
    pressed[9] = 1'b1;
    wait_pulse(200, got);
    check("clean_got_pulse", 32'(got), 32'd1);
    check("clean_key", 32'(key), 32'd9);
    check("clean_held_rise", 32'(key_held), 32'd1);
    repeat (60) @(negedge clk);
    check("clean_rows_frozen", 32'(rows), 32'hB);
    pressed[9] = 1'b0;
    measure_release(n);
    check("clean_held_fall_cycles", 32'(n), 32'd9);
    check("clean_one_pulse", 32'(pulses - p0), 32'd1);
    repeat (10) @(negedge clk);

    // Bouncing press row 1 col 3
    p0 = pulses;
    for (int i = 0; i < 10; i++) begin
      pressed[7] = ~pressed[7];
      repeat (3) @(negedge clk);
    end
    check("bounce_no_pulse", 32'(pulses - p0), 32'd0);
    pressed[7] = 1'b1;
    wait_pulse(100, got);
    check("bounce_got_pulse", 32'(got), 32'd1);
    check("bounce_key", 32'(key), 32'd7);
    repeat (10) @(negedge clk);
    pressed[7] = 1'b0;
    measure_release(n);
    check("bounce_held_fall_cycles", 32'(n), 32'd9);
    check("bounce_one_pulse", 32'(pulses - p0), 32'd1);
    repeat (10) @(negedge clk);

    // Release with glitches, key 12
    p0 = pulses;
    pressed[12] = 1'b1;
    wait_pulse(100, got);
    check("relb_got_pulse", 32'(got), 32'd1);
    check("relb_key", 32'(key), 32'd12);
    repeat (10) @(negedge clk);
    pressed[12] = 1'b0; repeat (3) @(negedge clk);
    pressed[12] = 1'b1; repeat (2) @(negedge clk);
    pressed[12] = 1'b0; repeat (4) @(negedge clk);
    pressed[12] = 1'b1; repeat (1) @(negedge clk);
    pressed[12] = 1'b0; repeat (5) @(negedge clk);
    check("relb_still_held", 32'(key_held), 32'd1);
    n = 0;
    while (key_held && n < 60) begin @(negedge clk); n++; end
    check("relb_released", 32'(key_held), 32'd0);
    check("relb_one_pulse", 32'(pulses - p0), 32'd1);
    repeat (10) @(negedge clk);

    // Chord on row 0, cols 0 and 2
    p0 = pulses;
    seen = 4'h0;
    pressed[0] = 1'b1; pressed[2] = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      for (int r = 0; r < 4; r++) if (!rows[r]) seen[r] = 1'b1;
    end
    check("chord_all_rows_scanned", 32'(seen), 32'hF);
    check("chord_no_pulse", 32'(pulses - p0), 32'd0);
    pressed[0] = 1'b0; pressed[2] = 1'b0;
    repeat (10) @(negedge clk);

    // Reset during a held key 15
    pressed[15] = 1'b1;
    wait_pulse(100, got);
    check("rst_first_pulse", 32'(got), 32'd1);
    check("rst_first_key", 32'(key), 32'd15);
    repeat (5) @(negedge clk);
    #2 nrst = 1'b0;
    #1;
    check("rst_now_key", 32'(key), 32'd0);
    check("rst_now_held", 32'(key_held), 32'd0);
    check("rst_now_rows", 32'(rows), 32'hE);
    check("rst_now_valid", 32'(key_valid), 32'd0);
    repeat (2) @(negedge clk);
    #2 nrst = 1'b1;
    p0 = pulses;
    wait_pulse(100, got);
    check("rst_repeat_pulse", 32'(got), 32'd1);
    check("rst_repeat_key", 32'(key), 32'd15);
    repeat (10) @(negedge clk);
    check("rst_repeat_one_pulse", 32'(pulses - p0), 32'd1);
    pressed[15] = 1'b0;
    measure_release(n);
    check("rst_held_fall_cycles", 32'(n), 32'd9);
    repeat (5) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
